// File: rtl/rou_msg_arbiter_pkg.sv
// Shared types and helpers for the ring message arbiter: command encodings,
// output-stage state and the message-valid test.
package rou_arb_pkg;

   typedef enum logic [1:0] {
      CMD_NONE  = 2'd0,
      CMD_READ  = 2'd1,
      CMD_WRITE = 2'd2,
      CMD_RESP  = 2'd3
   } cmd_e;

   localparam int CMD_LSB = 0;
   localparam int CMD_MSB = 1;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } ostate_e;

   function automatic logic msg_valid(input logic [CMD_MSB:CMD_LSB] msg_cmd);
      return msg_cmd != CMD_NONE;
   endfunction

endpackage

// File: rtl/rou_msg_arbiter_if.sv
// Bundle between the local message builders, the arbiter and rou_nif.
// The master modport is the arbiter side; slave is the builders/ring side.
interface rou_msg_arbiter_if #(
   parameter int WID  = 171,
   parameter int NREQ = 3
);
   logic [NREQ*WID-1:0] req_msg;
   logic [NREQ-1:0]     req_ack;
   logic [WID-1:0]      msg_out;
   logic                msg_out_ack;
   logic                busy;
   logic [2:0]          last_grant;

   modport master (
      input  req_msg, msg_out_ack,
      output req_ack, msg_out, busy, last_grant
   );

   modport slave (
      output req_msg, msg_out_ack,
      input  req_ack, msg_out, busy, last_grant
   );
endinterface

// File: rtl/rou_msg_arbiter_pick.sv
// Combinational round-robin pick: first set bit of req_i at or after start_i,
// wrapping N-1 -> 0. start_i must be below N.
module rou_rr_pick #(
   parameter int N = 3
) (
   input  logic [N-1:0] req_i,
   input  logic [2:0]   start_i,
   output logic [N-1:0] gnt_o,
   output logic [2:0]   idx_o,
   output logic         any_o
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   int pos;

   // NOTE: every output gets a default before the loop so no path leaves a latch.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      pos   = 0;
      for (int k = 0; k < N; k++) begin
         pos = int'(start_i) + k;
         if (pos >= N) pos = pos - N;
         if (!any_o && req_i[IW'(pos)]) begin
            any_o             = 1'b1;
            gnt_o[IW'(pos)]   = 1'b1;
            idx_o             = 3'(pos);
         end
      end
   end
endmodule

// File: rtl/rou_msg_arbiter.sv
// Round-robin message arbiter with burst stickiness and a one-entry output stage.
// Define ROU_ARB_PRIO_EN to give requester 0 starvation-limited strict priority.
module rou_msg_arbiter
   import rou_arb_pkg::*;
#(
   parameter int WID        = 171,
   parameter int NREQ       = 3,
   parameter int MAXBURST   = 4,
   parameter int STARVE_LIM = 8
) (
   input logic               clk,
   input logic               rst_n,
   rou_msg_arbiter_if.master arb
);
   // Burst and starve counters share one width, sized for the larger limit.
   localparam int         CNT_MAX  = (MAXBURST > STARVE_LIM) ? MAXBURST : STARVE_LIM;
   localparam int         CW       = $clog2(CNT_MAX + 1);
   localparam logic [2:0] LAST_IDX = 3'(NREQ - 1);

   ostate_e         state_q, state_d;
   logic [WID-1:0]  msg_q, msg_d;
   logic [2:0]      last_q, last_d;
   logic [CW-1:0]   burst_q, burst_d;

   logic [NREQ-1:0] valid, last_oh, gnt_oh, rr_gnt;
   logic [2:0]      gnt_idx, rr_idx, start_idx;
   logic            rr_any, slot_free, grant, others_pend;

   for (genvar g = 0; g < NREQ; g++) begin : g_valid
      assign valid[g] = msg_valid(arb.req_msg[g*WID+CMD_LSB +: CMD_MSB-CMD_LSB+1]);
   end

   // Holding reset also suppresses req_ack so no builder believes it was taken.
   assign slot_free = rst_n && (state_q == ST_EMPTY || arb.msg_out_ack);
   assign start_idx = (last_q == LAST_IDX) ? 3'd0 : last_q + 3'd1;
   assign last_oh   = {{(NREQ-1){1'b0}}, 1'b1} << last_q;

   rou_rr_pick #(.N(NREQ)) u_pick (
      .req_i   (valid),
      .start_i (start_idx),
      .gnt_o   (rr_gnt),
      .idx_o   (rr_idx),
      .any_o   (rr_any)
   );

`ifdef ROU_ARB_PRIO_EN
   logic [CW-1:0]   starve_q, starve_d;
   logic [NREQ-1:0] alt_gnt;
   logic [2:0]      alt_idx;
   logic            alt_any;

   rou_rr_pick #(.N(NREQ)) u_pick_alt (
      .req_i   ({valid[NREQ-1:1], 1'b0}),
      .start_i (start_idx),
      .gnt_o   (alt_gnt),
      .idx_o   (alt_idx),
      .any_o   (alt_any)
   );
`endif

   always_comb begin
      gnt_oh  = '0;
      gnt_idx = '0;
      if (slot_free) begin
`ifdef ROU_ARB_PRIO_EN
         if (valid[0] && (!alt_any || starve_q < CW'(STARVE_LIM))) begin
            gnt_oh[0] = 1'b1;
         end else if (valid[0]) begin
            gnt_oh  = alt_gnt;
            gnt_idx = alt_idx;
         end else
`endif
         if ((valid & last_oh) != '0 && burst_q < CW'(MAXBURST)) begin
            gnt_oh  = last_oh;
            gnt_idx = last_q;
         end else if (rr_any) begin
            gnt_oh  = rr_gnt;
            gnt_idx = rr_idx;
         end
      end
   end

   assign grant       = |gnt_oh;
   assign others_pend = |(valid & ~gnt_oh);

   always_comb begin
      state_d = state_q;
      msg_d   = msg_q;
      last_d  = last_q;
      burst_d = burst_q;
      if (grant) begin
         state_d = ST_FULL;
         msg_d   = arb.req_msg[gnt_idx*WID +: WID];
         last_d  = gnt_idx;
         // A lone requester keeps its count at 1 and is never throttled.
         if (!others_pend || gnt_idx != last_q) burst_d = CW'(1);
         else if (burst_q != '1)                burst_d = burst_q + CW'(1);
      end else if (state_q == ST_FULL && arb.msg_out_ack) begin
         state_d = ST_EMPTY;
         msg_d   = '0;
      end
   end

`ifdef ROU_ARB_PRIO_EN
   always_comb begin
      starve_d = starve_q;
      if (!alt_any)                          starve_d = '0;
      else if (grant && gnt_idx == 3'd0) begin
         if (starve_q != '1)                 starve_d = starve_q + CW'(1);
      end else if (grant)                    starve_d = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) starve_q <= '0;
      else        starve_q <= starve_d;
   end
`endif

   // NOTE: state uses non-blocking assignments; the message register is a plain
   // register (not a memory) and is cleared so the cmd field reads "no message".
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         msg_q   <= '0;
         last_q  <= '0;
         burst_q <= '0;
      end else begin
         state_q <= state_d;
         msg_q   <= msg_d;
         last_q  <= last_d;
         burst_q <= burst_d;
      end
   end

   assign arb.req_ack    = gnt_oh;
   assign arb.msg_out    = msg_q;
   assign arb.busy       = (state_q == ST_FULL);
   assign arb.last_grant = last_q;
endmodule
